pool_frame_buffer: RTL and testbench

- Ping-pong frame assembler directly upstream of max_pooling.
- Accepts the conv/activation stage's output as a serial pixel stream (valid/ready, raster order) and assembles complete ARRAY_WIDTH x ARRAY_WIDTH frames.
- Presents each complete frame as a flat unpacked array shaped exactly like max_pooling's input_vec, with a valid/ack handshake.
- Two banks let the next frame fill while the current one is being pooled.

---
 rtl/pool_frame_buffer.sv | 123 ++++++++++++
 tb/tb_pool_frame_buffer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_frame_buffer.sv
// Ping-pong frame assembler: collects a raster pixel stream into two ARRAY_W x ARRAY_W
// banks and presents one complete frame at a time to the pooling stage.
module pool_frame_buffer #(
    parameter int  DATA_W  = 9,
    parameter int  ARRAY_W = 4,
    localparam int N       = ARRAY_W * ARRAY_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [DATA_W-1:0] frame_out [0:N-1],
    output logic              frame_valid,
    input  logic              frame_ack,
    output logic              frame_err,
    input  logic              err_clr,
    output logic [15:0]       frames_done
);

    localparam int              IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL
    } bank_state_e;

    bank_state_e       state_q [2];
    bank_state_e       state_d [2];
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic [DATA_W-1:0] bank_q [2][N];
    logic [DATA_W-1:0] bank_d [2][N];
    logic              frame_valid_q, frame_valid_d;
    logic              frame_err_q, frame_err_d;
    logic [15:0]       frames_done_q, frames_done_d;

    logic accept;
    logic rel_fire;
    logic last_pix;
    logic err_set;

    assign s_ready     = (state_q[wr_bank_q] != FULL);
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign frames_done = frames_done_q;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            frame_out[i] = bank_q[rd_bank_q][i];
        end
    end

    always_comb begin
        state_d       = state_q;
        bank_d        = bank_q;
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        wr_idx_d      = wr_idx_q;
        frames_done_d = frames_done_q;

        accept   = s_valid && s_ready;
        rel_fire = frame_valid_q && frame_ack;
        last_pix = (wr_idx_q == LAST_IDX);

        // Release and completion never target the same bank: the write bank is
        // never FULL when accepting, while the read bank is FULL when releasing.
        if (rel_fire) begin
            state_d[rd_bank_q] = EMPTY;
            rd_bank_d          = ~rd_bank_q;
            frames_done_d      = frames_done_q + 16'd1;
        end

        if (accept) begin
            bank_d[wr_bank_q][wr_idx_q] = s_data;
            if (last_pix) begin
                state_d[wr_bank_q] = FULL;
                wr_idx_d           = '0;
                wr_bank_d          = ~wr_bank_q;
            end else begin
                state_d[wr_bank_q] = FILLING;
                wr_idx_d           = wr_idx_q + 1'b1;
            end
        end

        frame_valid_d = (state_d[rd_bank_d] == FULL);

        // Framing is purely count based; s_last only feeds the error flag.
        err_set     = accept && (s_last != last_pix);
        frame_err_d = err_set || (frame_err_q && !err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= EMPTY;
                for (int i = 0; i < N; i++) begin
                    bank_q[b][i] <= '0;
                end
            end
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            wr_idx_q      <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            frames_done_q <= '0;
        end else begin
            state_q       <= state_d;
            bank_q        <= bank_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            wr_idx_q      <= wr_idx_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            frames_done_q <= frames_done_d;
        end
    end

endmodule

// File: tb/tb_pool_frame_buffer.sv
// Bench for pool_frame_buffer: directed scenarios plus random throttling, all
// compared against a queue-based frame model.
module tb_pool_frame_buffer;

    localparam int DATA_W  = 9;
    localparam int ARRAY_W = 4;
    localparam int N       = ARRAY_W * ARRAY_W;

    typedef logic [DATA_W-1:0] frame_t [N];

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_last = 1'b0;
    logic              s_ready;
    logic [DATA_W-1:0] frame_out [0:N-1];
    logic              frame_valid;
    logic              frame_ack = 1'b0;
    logic              frame_err;
    logic              err_clr = 1'b0;
    logic [15:0]       frames_done;

    pool_frame_buffer #(
        .DATA_W (DATA_W),
        .ARRAY_W(ARRAY_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .frame_out  (frame_out),
        .frame_valid(frame_valid),
        .frame_ack  (frame_ack),
        .frame_err  (frame_err),
        .err_clr    (err_clr),
        .frames_done(frames_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model: completed frames awaiting ack, plus the partial frame
    frame_t pend[$];
    frame_t part;
    int     cnt      = 0;
    bit     exp_err  = 0;
    int     exp_done = 0;
    bit     acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic compare_all();
        check("s_ready", 32'(s_ready), 32'(pend.size() < 2));
        check("frame_valid", 32'(frame_valid), 32'(pend.size() > 0));
        check("frame_err", 32'(frame_err), 32'(exp_err));
        check("frames_done", 32'(frames_done), 32'(exp_done));
        if (pend.size() > 0) begin
            for (int i = 0; i < N; i++) begin
                check("frame_out", 32'(frame_out[i]), 32'(pend[0][i]));
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic step(input bit v, input logic [DATA_W-1:0] d, input bit l,
                        input bit a, input bit c, output bit accepted);
        bit rel;
        bit eset;
        s_valid   = v;
        s_data    = d;
        s_last    = l;
        frame_ack = a;
        err_clr   = c;
        accepted  = v && (pend.size() < 2);
        rel       = a && (pend.size() > 0);
        eset      = 0;
        @(posedge clk);
        if (rel) begin
            pend.delete(0);
            exp_done = (exp_done + 1) & 32'hFFFF;
        end
        if (accepted) begin
            part[cnt] = d;
            if (l != (cnt == N - 1)) eset = 1;
            if (cnt == N - 1) begin
                pend.push_back(part);
                cnt = 0;
            end else begin
                cnt++;
            end
        end
        if (eset) exp_err = 1;
        else if (c) exp_err = 0;
        #1;
        compare_all();
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input bit l, input bit a);
        for (int t = 0; t < 200; t++) begin
            step(1'b1, d, l, a, 1'b0, acc);
            if (acc) return;
        end
        check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_ack();
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
    endtask

    task automatic do_reset();
        logic [31:0] orv;
        #1;
        rst_n     = 1'b0;
        s_valid   = 1'b0;
        s_last    = 1'b0;
        frame_ack = 1'b0;
        err_clr   = 1'b0;
        #1;
        orv = '0;
        for (int i = 0; i < N; i++) orv = orv | 32'(frame_out[i]);
        check("rst_frame_out", orv, 32'd0);
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_done", 32'(frames_done), 32'd0);
        pend.delete();
        cnt      = 0;
        exp_err  = 0;
        exp_done = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_ready", 32'(s_ready), 32'd1);
    endtask

    initial begin
        int sent;
        int idx;
        logic [DATA_W-1:0] px;

        // single frame
        do_reset();
        for (int i = 0; i < N; i++) step(1'b1, DATA_W'(i), i == N - 1, 1'b0, 1'b0, acc);
        check("t1_valid", 32'(frame_valid), 32'd1);
        for (int i = 0; i < N; i++) check("t1_frame", 32'(frame_out[i]), 32'(i));
        idle_ack();
        check("t1_done", 32'(frames_done), 32'd1);
        check("t1_valid_drop", 32'(frame_valid), 32'd0);

        // backpressure with three frames
        do_reset();
        for (int i = 0; i < 2 * N; i++) step(1'b1, DATA_W'(i), (i % N) == N - 1, 1'b0, 1'b0, acc);
        check("t2_ready_lo", 32'(s_ready), 32'd0);
        for (int k = 0; k < 3; k++) step(1'b1, DATA_W'(32), 1'b0, 1'b0, 1'b0, acc);
        check("t2_stall_f0", 32'(frame_out[0]), 32'd0);
        check("t2_stall_f15", 32'(frame_out[15]), 32'd15);
        step(1'b1, DATA_W'(32), 1'b0, 1'b1, 1'b0, acc);
        check("t2_valid_hold", 32'(frame_valid), 32'd1);
        check("t2_switch", 32'(frame_out[0]), 32'd16);
        check("t2_ready_hi", 32'(s_ready), 32'd1);
        for (int i = 2 * N; i < 3 * N; i++) send(DATA_W'(i), i == 3 * N - 1, 1'b0);
        idle_ack();
        idle_ack();
        check("t2_done", 32'(frames_done), 32'd3);

        // ack of A on the same edge as B's last pixel
        do_reset();
        for (int i = 0; i < N; i++) step(1'b1, DATA_W'(100 + i), i == N - 1, 1'b0, 1'b0, acc);
        for (int i = 0; i < N - 1; i++) step(1'b1, DATA_W'(200 + i), 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, DATA_W'(200 + N - 1), 1'b1, 1'b1, 1'b0, acc);
        check("t3_valid", 32'(frame_valid), 32'd1);
        check("t3_b0", 32'(frame_out[0]), 32'd200);
        check("t3_b15", 32'(frame_out[15]), 32'd215);
        idle_ack();

        // framing errors
        do_reset();
        for (int i = 0; i < N; i++) begin
            step(1'b1, DATA_W'(i), (i == 7) || (i == N - 1), 1'b0, 1'b0, acc);
            if (i == 7) check("t4_early_last", 32'(frame_err), 32'd1);
        end
        check("t4_complete", 32'(frame_valid), 32'd1);
        idle_ack();
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
        check("t4_clr", 32'(frame_err), 32'd0);
        for (int i = 0; i < N; i++) step(1'b1, DATA_W'(i), 1'b0, 1'b0, 1'b0, acc);
        check("t4_missing_last", 32'(frame_err), 32'd1);
        idle_ack();
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
        for (int i = 0; i < N; i++) begin
            step(1'b1, DATA_W'(i), (i == 3) || (i == N - 1), 1'b0, i == 3, acc);
            if (i == 3) check("t4_set_wins", 32'(frame_err), 32'd1);
        end
        idle_ack();

        // reset while a frame is pending and another is partial
        do_reset();
        for (int i = 0; i < N; i++) step(1'b1, DATA_W'(50 + i), i == N - 1, 1'b0, 1'b0, acc);
        for (int i = 0; i < 9; i++) step(1'b1, DATA_W'(80 + i), 1'b0, 1'b0, 1'b0, acc);
        do_reset();
        for (int i = 0; i < N; i++) step(1'b1, DATA_W'(300 + i), i == N - 1, 1'b0, 1'b0, acc);
        for (int i = 0; i < N; i++) check("t5_fresh", 32'(frame_out[i]), 32'(300 + i));
        idle_ack();

        // random throttling, 50 frames
        do_reset();
        sent = 0;
        idx  = 0;
        px   = DATA_W'($urandom);
        for (int cyc = 0; cyc < 20000 && exp_done < 50; cyc++) begin
            bit v;
            bit a;
            v = (sent < 50) && ($urandom_range(0, 99) < 70);
            a = ($urandom_range(0, 99) < 50);
            step(v, px, idx == N - 1, a, 1'b0, acc);
            if (acc) begin
                px = DATA_W'($urandom);
                if (idx == N - 1) begin
                    idx = 0;
                    sent++;
                end else begin
                    idx++;
                end
            end
        end
        check("t6_done", 32'(frames_done), 32'd50);
        check("t6_err", 32'(frame_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
